// File: rtl/mem_req_master_if.sv
//------------------------------------------------------------------------------
// Module   : mem_req_master_if
// Brief    : Core command/response and data_mem request/response bundle.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface mem_req_master_if #(
  parameter int addr_width_p = 12
);
  logic                    cmd_valid_i;
  logic                    cmd_ready_o;
  logic                    cmd_wen_i;
  logic                    cmd_byte_i;
  logic                    cmd_signed_i;
  logic [addr_width_p-1:0] cmd_addr_i;
  logic [31:0]             cmd_wdata_i;
  logic                    resp_valid_o;
  logic [31:0]             resp_data_o;
  logic                    err_misalign_o;
  logic                    err_timeout_o;
  // mem_in_s  = {valid, wen, byte_not_word, write_data[31:0], yumi}  (36 bits)
  // mem_out_s = {valid, yumi, read_data[31:0]}                        (34 bits)
  logic [35:0]             port_flat_o;
  logic [addr_width_p-1:0] addr_o;
  logic [33:0]             port_flat_i;

  modport master (
    input  cmd_valid_i, cmd_wen_i, cmd_byte_i, cmd_signed_i, cmd_addr_i, cmd_wdata_i,
    input  port_flat_i,
    output cmd_ready_o, resp_valid_o, resp_data_o, err_misalign_o, err_timeout_o,
    output port_flat_o, addr_o
  );

  modport slave (
    output cmd_valid_i, cmd_wen_i, cmd_byte_i, cmd_signed_i, cmd_addr_i, cmd_wdata_i,
    output port_flat_i,
    input  cmd_ready_o, resp_valid_o, resp_data_o, err_misalign_o, err_timeout_o,
    input  port_flat_o, addr_o
  );
endinterface

`default_nettype wire

// File: rtl/mem_req_master.sv
//------------------------------------------------------------------------------
// Module   : mem_req_master
// Brief    : Single-outstanding load/store initiator for the data_mem valid/yumi
//            handshake with byte sign-extension, misalign rejection and timeout.
// Revision : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mem_req_master #(
  parameter int addr_width_p = 12,
  parameter int timeout_p    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_req_master_if.master      bus
);

  localparam int                 c_cnt_w    = (timeout_p > 2) ? $clog2(timeout_p) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(timeout_p - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_RSP = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t                  state_q;
  logic                    wen_q;
  logic                    byte_q;
  logic                    signed_q;
  logic [addr_width_p-1:0] addr_q;
  logic [31:0]             wdata_q;
  logic [c_cnt_w-1:0]      cnt_q;
  logic                    resp_valid_q;
  logic [31:0]             resp_data_q;
  logic                    misalign_q;
  logic                    timeout_q;

  logic                    mem_valid_d;
  logic                    mem_yumi_d;
  logic [31:0]             mem_rdata_d;
  logic                    req_yumi_d;
  logic [31:0]             load_data_d;

  assign mem_valid_d = bus.port_flat_i[33];
  assign mem_yumi_d  = bus.port_flat_i[32];
  assign mem_rdata_d = bus.port_flat_i[31:0];

  // Response acceptance must be same-cycle, so it is the one combinational output.
  assign req_yumi_d  = (state_q == S_WAIT_RSP) && mem_valid_d;
  assign load_data_d = byte_q ? {{24{signed_q & mem_rdata_d[7]}}, mem_rdata_d[7:0]}
                              : mem_rdata_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wen_q        <= 1'b0;
      byte_q       <= 1'b0;
      signed_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      misalign_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          resp_valid_q <= 1'b0;
          misalign_q   <= 1'b0;
          if (bus.cmd_valid_i) begin
            wen_q    <= bus.cmd_wen_i;
            byte_q   <= bus.cmd_byte_i;
            signed_q <= bus.cmd_signed_i;
            addr_q   <= bus.cmd_addr_i;
            wdata_q  <= bus.cmd_wdata_i;
            if (!bus.cmd_byte_i && (bus.cmd_addr_i[1:0] != 2'b00)) begin
              state_q      <= S_DONE;
              resp_valid_q <= 1'b1;
              resp_data_q  <= '0;
              misalign_q   <= 1'b1;
            end else begin
              state_q <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (mem_yumi_d) begin
            state_q <= S_WAIT_RSP;
            cnt_q   <= '0;
          end
        end
        S_WAIT_RSP: begin
          if (mem_valid_d) begin
            state_q      <= S_DONE;
            resp_valid_q <= 1'b1;
            resp_data_q  <= wen_q ? 32'd0 : load_data_d;
          end else if (cnt_q == c_cnt_last) begin
            state_q      <= S_DONE;
            resp_valid_q <= 1'b1;
            resp_data_q  <= '0;
            timeout_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
          misalign_q   <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready_o    = (state_q == S_IDLE);
  assign bus.resp_valid_o   = resp_valid_q;
  assign bus.resp_data_o    = resp_data_q;
  assign bus.err_misalign_o = misalign_q;
  assign bus.err_timeout_o  = timeout_q;
  assign bus.port_flat_o    = {(state_q == S_ISSUE), wen_q, byte_q, wdata_q, req_yumi_d};
  assign bus.addr_o         = addr_q;

endmodule

`default_nettype wire
